// File: rtl/sigdelay_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : sigdelay_ctrl
//  Purpose  : Sequencer for the audio delay-line datapath. Gates the address
//             counter enable and the voice-RAM write/read strobes once per
//             sample tick, owns the active delay offset, and primes the buffer
//             after start or an offset change so that no stale RAM contents
//             are ever flagged as a valid delayed sample.
//  Ports    : clk, rst          - clock, synchronous active-high reset
//             start, stop       - begin operation (IDLE only) / return to IDLE
//             sample_tick       - one-cycle strobe per audio sample
//             offset_load       - latch offset_req as the new delay
//             offset_req        - requested delay in samples (0 loads as 1)
//             ctr_en, wr_en,    - registered one-cycle strobes, issued the
//             rd_en               cycle after the tick that caused them
//             offset            - active offset to the datapath
//             out_valid         - rd_en delayed by the RAM read latency
//             state             - 0=IDLE, 1=FILL, 2=RUN
//  Revision : 1.0 - initial release
// ============================================================================
module sigdelay_ctrl #(
   parameter int A_WIDTH = 9,
   parameter int D_WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               stop,
   input  logic               sample_tick,
   input  logic               offset_load,
   input  logic [A_WIDTH-1:0] offset_req,
   output logic               ctr_en,
   output logic               wr_en,
   output logic               rd_en,
   output logic [A_WIDTH-1:0] offset,
   output logic               out_valid,
   output logic [1:0]         state
);

   // Sample width is carried for interface symmetry only; reject nonsense
   // parameterisations at elaboration time.
   if (D_WIDTH < 1 || A_WIDTH < 2) begin : g_param_check
      $error("sigdelay_ctrl: A_WIDTH must be >= 2 and D_WIDTH >= 1");
   end

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_FILL = 2'd1,
      S_RUN  = 2'd2
   } state_t;

   localparam logic [A_WIDTH-1:0] c_offset_min = {{(A_WIDTH-1){1'b0}}, 1'b1};

   state_t             state_q, state_d;
   logic [A_WIDTH-1:0] offset_q, offset_d;
   logic [A_WIDTH-1:0] fill_cnt_q, fill_cnt_d;
   logic               ctr_en_q, ctr_en_d;
   logic               wr_en_q, wr_en_d;
   logic               rd_en_q, rd_en_d;
   logic               out_valid_q, out_valid_d;

   logic [A_WIDTH-1:0] offset_clamped;
   logic [A_WIDTH-1:0] fill_inc;

   // A zero offset would make read and write hit the same address in the
   // same cycle, so it is promoted to the minimum delay of one sample.
   assign offset_clamped = (offset_req == '0) ? c_offset_min : offset_req;
   assign fill_inc       = fill_cnt_q + c_offset_min;

   always_comb begin
      state_d     = state_q;
      offset_d    = offset_q;
      fill_cnt_d  = fill_cnt_q;
      ctr_en_d    = 1'b0;
      wr_en_d     = 1'b0;
      rd_en_d     = 1'b0;
      // A read already issued always completes, even across stop or an
      // offset change; suppression after re-priming falls out naturally
      // because FILL never issues reads.
      out_valid_d = rd_en_q;

      if (stop) begin
         state_d = S_IDLE;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (offset_load) begin
                  offset_d = offset_clamped;
               end
               if (start) begin
                  fill_cnt_d = '0;
                  state_d    = S_FILL;
               end
            end

            S_FILL, S_RUN: begin
               if (offset_load) begin
                  // Re-prime under the new offset; a coincident tick is the
                  // first write of the new fill.
                  offset_d   = offset_clamped;
                  fill_cnt_d = '0;
                  state_d    = S_FILL;
                  if (sample_tick) begin
                     ctr_en_d   = 1'b1;
                     wr_en_d    = 1'b1;
                     fill_cnt_d = c_offset_min;
                     if (offset_clamped == c_offset_min) begin
                        state_d = S_RUN;
                     end
                  end
               end else if (sample_tick) begin
                  ctr_en_d = 1'b1;
                  wr_en_d  = 1'b1;
                  if (state_q == S_FILL) begin
                     fill_cnt_d = fill_inc;
                     if (fill_inc == offset_q) begin
                        state_d = S_RUN;
                     end
                  end else begin
                     rd_en_d = 1'b1;
                  end
               end
            end

            default: begin
               state_d = S_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         offset_q    <= c_offset_min;
         fill_cnt_q  <= '0;
         ctr_en_q    <= 1'b0;
         wr_en_q     <= 1'b0;
         rd_en_q     <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         offset_q    <= offset_d;
         fill_cnt_q  <= fill_cnt_d;
         ctr_en_q    <= ctr_en_d;
         wr_en_q     <= wr_en_d;
         rd_en_q     <= rd_en_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign ctr_en    = ctr_en_q;
   assign wr_en     = wr_en_q;
   assign rd_en     = rd_en_q;
   assign offset    = offset_q;
   assign out_valid = out_valid_q;
   assign state     = state_q;

endmodule
`default_nettype wire

// File: tb/tb_sigdelay_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sigdelay_ctrl
//  Purpose  : Scoreboard bench for sigdelay_ctrl. Stimulus pushes the
//             hand-computed strobe set and out_valid cycle for each tick; a
//             separate monitor pops and compares whenever the DUT strobes.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sigdelay_ctrl;

   localparam int A_WIDTH = 9;
   localparam int D_WIDTH = 8;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic               start = 1'b0;
   logic               stop = 1'b0;
   logic               sample_tick = 1'b0;
   logic               offset_load = 1'b0;
   logic [A_WIDTH-1:0] offset_req = '0;
   logic               ctr_en, wr_en, rd_en, out_valid;
   logic [A_WIDTH-1:0] offset;
   logic [1:0]         state;

   sigdelay_ctrl #(.A_WIDTH(A_WIDTH), .D_WIDTH(D_WIDTH)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .stop       (stop),
      .sample_tick(sample_tick),
      .offset_load(offset_load),
      .offset_req (offset_req),
      .ctr_en     (ctr_en),
      .wr_en      (wr_en),
      .rd_en      (rd_en),
      .offset     (offset),
      .out_valid  (out_valid),
      .state      (state)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int cyc;
      bit wr;
      bit rd;
   } strobe_t;

   strobe_t sq[$];
   int      vq[$];
   int      checks = 0;
   int      errors = 0;
   bit      mon_on = 1'b0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: runs independently of the stimulus, consuming expectations.
   always @(negedge clk) begin
      if (mon_on) begin
         if (ctr_en || wr_en || rd_en) begin
            if (sq.size() == 0) begin
               chk("unexpected_strobe_cycle", cyc, -1);
            end else begin
               strobe_t e;
               e = sq.pop_front();
               chk("strobe_cycle", cyc, e.cyc);
               chk("ctr_en", int'(ctr_en), 1);
               chk("wr_en", int'(wr_en), int'(e.wr));
               chk("rd_en", int'(rd_en), int'(e.rd));
            end
         end
         if (out_valid) begin
            if (vq.size() == 0) begin
               chk("unexpected_out_valid_cycle", cyc, -1);
            end else begin
               chk("out_valid_cycle", cyc, vq.pop_front());
            end
         end
      end
   end

   // One cycle of stimulus; entered just after a negedge. es is the state
   // expected while the inputs are presented; ew/er the strobes they cause.
   task automatic step(input bit tick, input bit ld, input int req,
                       input bit st, input bit sp, input int es,
                       input bit ew, input bit er);
      strobe_t e;
      chk("state_at_input", int'(state), es);
      sample_tick = tick;
      offset_load = ld;
      offset_req  = A_WIDTH'(req);
      start       = st;
      stop        = sp;
      if (ew || er) begin
         e.cyc = cyc + 1;
         e.wr  = ew;
         e.rd  = er;
         sq.push_back(e);
         if (er) vq.push_back(cyc + 2);
      end
      @(negedge clk);
      sample_tick = 1'b0;
      offset_load = 1'b0;
      start       = 1'b0;
      stop        = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic tick(input int es, input bit ew, input bit er);
      step(1'b1, 1'b0, 0, 1'b0, 1'b0, es, ew, er);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      // --- reset ---
      rst = 1'b1;
      idle(3);
      rst = 1'b0;
      mon_on = 1'b1;
      chk("reset_state", int'(state), 0);
      chk("reset_offset", int'(offset), 1);
      chk("reset_strobes", int'({ctr_en, wr_en, rd_en, out_valid}), 0);

      // --- offset 4, ten ticks spaced three cycles apart ---
      step(1'b0, 1'b1, 4, 1'b1, 1'b0, 0, 1'b0, 1'b0);
      chk("offset_after_load4", int'(offset), 4);
      for (int i = 0; i < 10; i++) begin
         tick((i < 4) ? 1 : 2, 1'b1, (i >= 4));
         idle(2);
      end

      // --- offset_req 0 clamps to 1 ---
      step(1'b0, 1'b0, 0, 1'b0, 1'b1, 2, 1'b0, 1'b0);
      chk("state_after_stop", int'(state), 0);
      step(1'b0, 1'b1, 0, 1'b1, 1'b0, 0, 1'b0, 1'b0);
      chk("offset_clamped", int'(offset), 1);
      tick(1, 1'b1, 1'b0);
      idle(1);
      tick(2, 1'b1, 1'b1);
      idle(1);
      tick(2, 1'b1, 1'b1);
      idle(2);

      // --- offset change during RUN with a coincident tick ---
      step(1'b0, 1'b0, 0, 1'b0, 1'b1, 2, 1'b0, 1'b0);
      step(1'b0, 1'b1, 4, 1'b1, 1'b0, 0, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         tick(1, 1'b1, 1'b0);
         idle(1);
      end
      tick(2, 1'b1, 1'b1);
      step(1'b1, 1'b1, 7, 1'b0, 1'b0, 2, 1'b1, 1'b0);
      chk("offset_reload7", int'(offset), 7);
      chk("state_reload7", int'(state), 1);
      idle(1);
      for (int i = 0; i < 6; i++) begin
         tick(1, 1'b1, 1'b0);
         idle(1);
      end
      tick(2, 1'b1, 1'b1);
      idle(2);

      // --- stop coincident with a RUN tick ---
      step(1'b1, 1'b0, 0, 1'b0, 1'b1, 2, 1'b0, 1'b0);
      chk("state_after_stop_tick", int'(state), 0);
      chk("offset_kept_after_stop", int'(offset), 7);
      for (int i = 0; i < 3; i++) begin
         tick(0, 1'b0, 1'b0);
      end
      idle(2);

      // --- back-to-back ticks, offset 2 ---
      step(1'b0, 1'b1, 2, 1'b1, 1'b0, 0, 1'b0, 1'b0);
      tick(1, 1'b1, 1'b0);
      tick(1, 1'b1, 1'b0);
      for (int i = 0; i < 6; i++) begin
         tick(2, 1'b1, 1'b1);
      end
      idle(3);

      // --- reset in the middle of FILL ---
      step(1'b0, 1'b0, 0, 1'b0, 1'b1, 2, 1'b0, 1'b0);
      step(1'b0, 1'b1, 5, 1'b1, 1'b0, 0, 1'b0, 1'b0);
      tick(1, 1'b1, 1'b0);
      tick(1, 1'b1, 1'b0);
      idle(1);
      rst = 1'b1;
      sample_tick = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      sample_tick = 1'b0;
      chk("midfill_reset_state", int'(state), 0);
      chk("midfill_reset_offset", int'(offset), 1);
      chk("midfill_reset_strobes", int'({ctr_en, wr_en, rd_en, out_valid}), 0);
      step(1'b0, 1'b0, 0, 1'b1, 1'b0, 0, 1'b0, 1'b0);
      tick(1, 1'b1, 1'b0);
      tick(2, 1'b1, 1'b1);
      idle(4);

      // --- everything expected must have been seen ---
      chk("strobes_outstanding", sq.size(), 0);
      chk("valids_outstanding", vq.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
